fetch_sequencer: RTL and testbench

Sequencer that owns the program counter for the 72-bit core and drives the combinational `InstructionFetch` memory. Each cycle it presents the current PC as the fetch address, captures the returned instruction with its PC into a 2-entry buffer, and hands the instructions to decode over a valid/ready handshake. It handles start/halt control, backpressure from decode, and branch redirects with a buffer flush. It sits between the fetch memory and the decode stage.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_skid_buf.sv | 76 +++++++
 rtl/fetch_sequencer.sv | 103 ++++++++++
 tb/tb_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: default widths, FSM encoding
// and the buffered fetch entry.
package fetch_pkg;

  localparam int unsigned DefAddrW  = 72;
  localparam int unsigned DefInstrW = 72;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalted
  } state_e;

  typedef struct packed {
    logic [DefAddrW-1:0]  pc;
    logic [DefInstrW-1:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO with a registered head, used to decouple fetch from decode.
// Flush discards everything; a pop in the flushing cycle still completes.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter type buf_entry_t = fetch_pkg::entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  buf_entry_t push_data,
  input  logic       pop,
  input  logic       flush,
  output buf_entry_t head,
  output logic [1:0] count
);

  buf_entry_t head_q, head_d;
  buf_entry_t tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       push_ok;
  logic       pop_ok;

  // Guard against misuse: never pop empty, never overwrite when full.
  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = push_data;
          end else begin
            tail_d = push_data;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = push_data;
          end else begin
            head_d = tail_q;
            tail_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner for the fetch stage: drives the instruction memory,
// buffers returned instructions and hands them to decode over valid/ready.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned      ADDR_W   = DefAddrW,
  parameter int unsigned      INSTR_W  = DefInstrW,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               busy
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } seq_entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count;
  logic              pop;
  logic              capture;
  seq_entry_t        push_data;
  seq_entry_t        head;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  // Redirect and halt both suppress capture; a full buffer only accepts
  // when it is popped in the same cycle.
  assign capture = (state_q == StFetch) && !redirect_valid && !halt &&
                   ((count != 2'd2) || pop);

  assign push_data.pc    = pc_q;
  assign push_data.instr = imem_instr;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (capture) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StHalted: begin
        if (start && !halt) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (halt) begin
          state_d = StHalted;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_skid_buf #(
    .buf_entry_t(seq_entry_t)
  ) u_skid_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (capture),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .count    (count)
  );

  assign imem_addr = pc_q;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign busy      = (state_q == StFetch) || (count != 2'd0);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a queue-based reference model.
module tb_fetch_sequencer;

  localparam int unsigned AW = 72;
  localparam logic [AW-1:0] WRAP_PC = {{71{1'b1}}, 1'b0};

  logic          clk = 1'b0;
  logic          rst;
  logic          start, halt, redirect_valid, out_ready;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_addr, imem_instr, out_instr, out_pc;
  logic          out_valid, busy;

  logic          w_start;
  logic [AW-1:0] w_addr, w_instr, w_out_instr, w_out_pc;
  logic          w_valid, w_busy;

  always #5 clk = ~clk;

  assign imem_instr = imem_addr + 72'h100;
  assign w_instr    = w_addr + 72'h100;

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .halt          (halt),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .busy          (busy)
  );

  fetch_sequencer #(
    .RESET_PC(WRAP_PC)
  ) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .start         (w_start),
    .halt          (1'b0),
    .redirect_valid(1'b0),
    .redirect_pc   ('0),
    .imem_addr     (w_addr),
    .imem_instr    (w_instr),
    .out_valid     (w_valid),
    .out_ready     (1'b1),
    .out_instr     (w_out_instr),
    .out_pc        (w_out_pc),
    .busy          (w_busy)
  );

  // Reference model: a plain queue of delivered-to-be entries plus a PC.
  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] instr;
  } ment_t;

  ment_t         q[$];
  logic [AW-1:0] m_pc;
  bit            m_run;
  int            vec_cnt = 0;
  int            err_cnt = 0;

  function automatic logic [AW-1:0] mem_word(logic [AW-1:0] a);
    return a + 72'h100;
  endfunction

  task automatic check(string tag, logic [AW-1:0] got, logic [AW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", AW'(out_valid), AW'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_pc", out_pc, q[0].pc);
      check("out_instr", out_instr, q[0].instr);
    end
    check("imem_addr", imem_addr, m_pc);
    check("busy", AW'(busy), AW'(m_run || q.size() != 0));
  endtask

  // Advance the model by one clock using the inputs currently applied,
  // then let the DUT take the same edge and compare.
  task automatic step();
    ment_t e;
    bit    pop;
    if (rst) begin
      q.delete();
      m_pc  = '0;
      m_run = 1'b0;
    end else begin
      pop = (q.size() != 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (redirect_valid) begin
        q.delete();
        m_pc = redirect_pc;
      end else if (m_run && !halt && q.size() < 2) begin
        e.pc    = m_pc;
        e.instr = mem_word(m_pc);
        q.push_back(e);
        m_pc = m_pc + 72'd1;
      end
      if (m_run && halt) m_run = 1'b0;
      else if (!m_run && start && !halt) m_run = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    w_start        = 1'b0;
    m_pc           = '0;
    m_run          = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", AW'(out_valid), '0);
    check("rst_instr", out_instr, '0);
    check("rst_pc", out_pc, '0);
    check("rst_addr", imem_addr, '0);
    check("rst_busy", AW'(busy), '0);
    check("rst_wrap_addr", w_addr, WRAP_PC);
    rst = 1'b0;

    // Wrap-around instance: PCs 2^72-2, 2^72-1, 0, 1.
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("wrap_valid", AW'(w_valid), 72'd1);
      check("wrap_pc", w_out_pc, WRAP_PC + AW'(k));
      check("wrap_instr", w_out_instr, WRAP_PC + AW'(k) + 72'h100);
    end

    // Start with decode stalled: buffer fills, PC holds at 2, then drains.
    start     = 1'b1;
    out_ready = 1'b0;
    step();
    start = 1'b0;
    steps(6);
    check("stall_addr", imem_addr, 72'd2);
    out_ready = 1'b1;
    steps(6);

    // Redirect while full and popping.
    out_ready = 1'b0;
    steps(3);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 72'h40;
    step();
    redirect_valid = 1'b0;
    steps(4);

    // Halt with two buffered entries, drain, then resume.
    out_ready = 1'b0;
    steps(3);
    halt = 1'b1;
    step();
    halt = 1'b0;
    steps(2);
    out_ready = 1'b1;
    steps(4);
    check("halt_busy", AW'(busy), '0);
    start = 1'b1;
    step();
    start = 1'b0;
    steps(4);

    // Redirect and halt together.
    redirect_valid = 1'b1;
    halt           = 1'b1;
    redirect_pc    = WRAP_PC;
    step();
    redirect_valid = 1'b0;
    halt           = 1'b0;
    steps(2);
    start = 1'b1;
    step();
    start = 1'b0;
    steps(5);

    // Asynchronous reset mid-stream, observed before the next edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", AW'(out_valid), '0);
    check("arst_busy", AW'(busy), '0);
    check("arst_pc", out_pc, '0);
    check("arst_addr", imem_addr, '0);
    step();
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      start          = ($urandom_range(0, 99) < 20);
      halt           = ($urandom_range(0, 99) < 5);
      redirect_valid = ($urandom_range(0, 99) < 6);
      out_ready      = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 1) == 0) redirect_pc = AW'($urandom_range(0, 255));
      else redirect_pc = WRAP_PC + AW'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
